// File: rtl/mul_pkg.sv
// Shared definitions for the serial multiplier datapath helpers.
package mul_pkg;

  localparam int MANT_W = 25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bu2_serial_cell.sv
// One bit of the copy-until-first-one, then invert rule for two's complement negation.
module bu2_serial_cell (
  input  logic b,
  input  logic neg,
  input  logic seen_one,
  output logic r,
  output logic seen_one_nxt
);

  assign r            = (neg & seen_one) ? ~b : b;
  assign seen_one_nxt = seen_one | b;

endmodule

// File: rtl/bu2_to_sm_serial.sv
// LSB-first bit-serial two's complement to sign-magnitude decoder, one word in flight.
module bu2_to_sm_serial
  import mul_pkg::*;
#(
  parameter int W  = MANT_W,
  parameter int CW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_sign,
  output logic [W-1:0] out_mag,
  output logic         out_maxneg
);

  localparam logic [W-1:0] MAXNEG = {1'b1, {(W-1){1'b0}}};

  state_t        state;
  logic [W-1:0]  sr;
  logic [W-1:0]  mag;
  logic [CW-1:0] cnt;
  logic          seen_one;
  logic          sign_q;
  logic          maxneg_q;
  logic          valid_q;
  logic          r;
  logic          seen_one_nxt;
  logic [W-1:0]  mag_nxt;

  bu2_serial_cell u_cell (
    .b            (sr[0]),
    .neg          (sign_q),
    .seen_one     (seen_one),
    .r            (r),
    .seen_one_nxt (seen_one_nxt)
  );

  assign mag_nxt = {r, mag[W-1:1]};

  // The last BUSY edge also latches maxneg from the final magnitude, keeping it registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      mag      <= '0;
      cnt      <= '0;
      seen_one <= 1'b0;
      sign_q   <= 1'b0;
      maxneg_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= BUSY;
            sr       <= in_data;
            sign_q   <= in_data[W-1];
            cnt      <= '0;
            seen_one <= 1'b0;
            mag      <= '0;
          end
        end
        BUSY: begin
          mag      <= mag_nxt;
          sr       <= sr >> 1;
          seen_one <= seen_one_nxt;
          cnt      <= cnt + 1'b1;
          if (cnt == CW'(W-1)) begin
            state    <= DONE;
            valid_q  <= 1'b1;
            maxneg_q <= sign_q && (mag_nxt == MAXNEG);
          end
        end
        DONE: begin
          if (out_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = valid_q;
  assign out_sign   = sign_q;
  assign out_mag    = mag;
  assign out_maxneg = maxneg_q;

endmodule

// File: tb/tb_bu2_to_sm_serial.sv
// Bench for bu2_to_sm_serial: directed table, corner sequences, exhaustive W=8, random W=25.
module tb_bu2_to_sm_serial;

  logic        clk = 1'b0;
  logic        rst;

  logic        iv8, ir8, ov8, or8, os8, om8;
  logic [7:0]  id8, mag8;
  logic        iv25, ir25, ov25, or25, os25, om25;
  logic [24:0] id25, mag25;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] din;
    logic       sign;
    logic [7:0] mag;
    logic       maxneg;
    int         bp;
    logic       hold;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  bu2_to_sm_serial #(.W(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .out_valid(ov8), .out_ready(or8),
    .out_sign(os8), .out_mag(mag8), .out_maxneg(om8)
  );

  bu2_to_sm_serial #(.W(25)) dut25 (
    .clk(clk), .rst(rst),
    .in_valid(iv25), .in_ready(ir25), .in_data(id25),
    .out_valid(ov25), .out_ready(or25),
    .out_sign(os25), .out_mag(mag25), .out_maxneg(om25)
  );

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, got, exp);
  endtask

  // One W=8 transaction: accept, count latency, check result, hold under backpressure, hand off.
  task automatic apply_stimulus8(input logic [7:0] d, input logic es, input logic [7:0] em,
                                 input logic emx, input int bp, input logic hold);
    int lat;
    logic s0, x0;
    logic [7:0] m0;
    lat = 0;
    while (!ir8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_output("in_ready_idle", {31'd0, ir8}, 32'd1);
    iv8 = 1'b1;
    id8 = d;
    @(posedge clk);
    @(negedge clk);
    iv8 = hold;
    id8 = 8'($urandom);
    lat = 0;
    while (!ov8 && lat < 24) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    iv8 = 1'b0;
    check_output("latency8", lat, 32'd8);
    check_output("sign8", {31'd0, os8}, {31'd0, es});
    check_output("mag8", {24'd0, mag8}, {24'd0, em});
    check_output("maxneg8", {31'd0, om8}, {31'd0, emx});
    check_output("in_ready_done", {31'd0, ir8}, 32'd0);
    s0 = os8;
    x0 = om8;
    m0 = mag8;
    or8 = 1'b0;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_output("bp_hold", {21'd0, ov8, ir8, s0 ^ os8, x0 ^ om8, m0 ^ mag8},
                   {21'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    end
    or8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or8 = 1'b0;
    check_output("handoff", {30'd0, ov8, ir8}, 32'd1);
  endtask

  task automatic apply_stimulus25(input logic [24:0] d);
    int lat;
    logic [24:0] em;
    em = d[24] ? (~d + 25'd1) : d;
    lat = 0;
    while (!ir25 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    iv25 = 1'b1;
    id25 = d;
    @(posedge clk);
    @(negedge clk);
    id25 = 25'($urandom);
    lat = 0;
    while (!ov25 && lat < 75) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    iv25 = 1'b0;
    check_output("latency25", lat, 32'd25);
    check_output("sign25", {31'd0, os25}, {31'd0, d[24]});
    check_output("mag25", {7'd0, mag25}, {7'd0, em});
    check_output("maxneg25", {31'd0, om25}, {31'd0, (d == 25'h1000000)});
    or25 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or25 = 1'b0;
  endtask

  initial begin
    int acc [$];
    int idx;
    logic [7:0] x;
    logic [24:0] y;

    vecs[0] = '{8'h05, 1'b0, 8'h05, 1'b0, 0, 1'b0};
    vecs[1] = '{8'hFB, 1'b1, 8'h05, 1'b0, 5, 1'b0};
    vecs[2] = '{8'h81, 1'b1, 8'h7F, 1'b0, 0, 1'b1};
    vecs[3] = '{8'h80, 1'b1, 8'h80, 1'b1, 2, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0};
    vecs[5] = '{8'hFF, 1'b1, 8'h01, 1'b0, 1, 1'b1};
    vecs[6] = '{8'h7F, 1'b0, 8'h7F, 1'b0, 0, 1'b0};

    rst = 1'b1;
    iv8 = 1'b0; or8 = 1'b0; id8 = '0;
    iv25 = 1'b0; or25 = 1'b0; id25 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_output("reset8", {27'd0, ov8, ir8, os8, om8, |mag8}, {27'd0, 5'b01000});
    check_output("reset25", {27'd0, ov25, ir25, os25, om25, |mag25}, {27'd0, 5'b01000});

    foreach (vecs[i])
      apply_stimulus8(vecs[i].din, vecs[i].sign, vecs[i].mag, vecs[i].maxneg,
                      vecs[i].bp, vecs[i].hold);

    // Back-to-back words with in_valid and out_ready held high.
    iv8 = 1'b1;
    or8 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      id8 = 8'($urandom);
      if (ir8) acc.push_back(c);
      @(posedge clk);
      @(negedge clk);
    end
    iv8 = 1'b0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
    end
    or8 = 1'b0;
    check_output("accept_count", acc.size() >= 3, 32'd1);
    if (acc.size() >= 3) begin
      check_output("spacing_a", acc[1] - acc[0], 32'd10);
      check_output("spacing_b", acc[2] - acc[1], 32'd10);
    end

    // Reset while busy with cnt==3.
    iv8 = 1'b1;
    id8 = 8'h33;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_output("reset_midop", {28'd0, ov8, ir8, os8, |mag8}, {28'd0, 4'b0100});
    apply_stimulus8(8'hF0, 1'b1, 8'h10, 1'b0, 0, 1'b0);

    for (int i = 0; i < 256; i++) begin
      x = 8'(i);
      apply_stimulus8(x, x[7], x[7] ? (~x + 8'd1) : x, (x == 8'h80), i % 3, 1'(i % 2));
    end

    apply_stimulus25(25'h1000000);
    apply_stimulus25(25'h1FFFFFF);
    apply_stimulus25(25'h0000000);
    for (int i = 0; i < 150; i++) begin
      y = 25'($urandom);
      apply_stimulus25(y);
    end

    idx = n_checks - n_pass;
    if (idx != 0) $display("[TB] %0d comparisons did not match", idx);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
